// File: rtl/rc4_pkg.sv
// Shared definitions for the RC4 key-schedule controller: the 2-bit command
// encoding understood by the key-schedule block and the controller state set.
package rc4_pkg;

   // Commands driven on ns to the key-schedule block
   localparam logic [1:0] NS_INIT       = 2'b00;
   localparam logic [1:0] NS_KEY_GENE   = 2'b01;
   localparam logic [1:0] NS_EN_DE_CODE = 2'b10;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      KSA    = 3'd1,
      SETTLE = 3'd2,
      STREAM = 3'd3,
      DONE   = 3'd4,
      SCRUB  = 3'd5
   } ctrl_state_t;

   // Command the key-schedule block must see while the controller sits in st.
   // SCRUB reuses EN_DE_CODE: leaving that mode is what clears the block's table.
   function automatic logic [1:0] ns_of_state(input ctrl_state_t st);
      case (st)
         KSA, SETTLE:   ns_of_state = NS_KEY_GENE;
         STREAM, SCRUB: ns_of_state = NS_EN_DE_CODE;
         default:       ns_of_state = NS_INIT;
      endcase
   endfunction

endpackage

// File: rtl/rc4_byte_slot.sv
// Single-entry output slot between the cipher step and the downstream consumer.
// A step loads the slot, a downstream accept empties it, flush drops its content.
module rc4_byte_slot (
   input  logic clk,
   input  logic rst,
   input  logic step,
   input  logic accept,
   input  logic flush,
   output logic out_valid,
   output logic free
);

   logic valid_q, valid_d;

   // Room for a new byte when empty, or when the held byte leaves this cycle
   assign free      = ~valid_q | accept;
   assign out_valid = valid_q;

   // Next occupancy: flush beats step, step beats accept
   always_comb begin
      valid_d = valid_q;
      if (flush) begin
         valid_d = 1'b0;
      end else if (step) begin
         valid_d = 1'b1;
      end else if (accept) begin
         valid_d = 1'b0;
      end
   end

   // Occupancy register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q <= 1'b0;
      end else begin
         valid_q <= valid_d;
      end
   end

endmodule

// File: rtl/rc4_seq_ctrl.sv
// Top-level sequencer for the RC4 key-schedule block: runs the key schedule
// under a watchdog, gates one cipher step per host byte into a single-entry
// output slot, and scrubs the key-schedule block between messages.
module rc4_seq_ctrl
   import rc4_pkg::*;
#(
   parameter int unsigned LEN_W       = 16,
   parameter int unsigned KSA_TIMEOUT = 320,
   parameter int unsigned TMO_W       = 9
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [LEN_W-1:0] msg_len,
   input  logic             abort,
   input  logic             ksa_ready,
   output logic [1:0]       ns,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             prga_step,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [LEN_W-1:0] byte_idx,
   output logic             busy,
   output logic             done,
   output logic             error
);

   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(KSA_TIMEOUT - 1);

   ctrl_state_t      state_q, state_d;
   logic [1:0]       ns_q;
   logic [LEN_W-1:0] len_q, len_d;
   logic [LEN_W-1:0] idx_q, idx_d;
   logic [TMO_W-1:0] wdog_q, wdog_d;
   logic             error_q, error_d;
   logic             slot_free;
   logic             last_byte;
   logic             slot_flush;

   assign last_byte = (idx_q == len_q);

   // Host handshake; abort also closes the gate so no byte is taken from the
   // host and then thrown away by the scrub that follows
   assign in_ready  = (state_q == STREAM) && !last_byte && slot_free && !abort;
   assign prga_step = in_valid & in_ready;

   // Any pending byte is dropped on the way into SCRUB
   assign slot_flush = (state_d == SCRUB);

   rc4_byte_slot u_slot (
      .clk       (clk),
      .rst       (rst),
      .step      (prga_step),
      .accept    (out_ready),
      .flush     (slot_flush),
      .out_valid (out_valid),
      .free      (slot_free)
   );

   // Next-state, counters and watchdog
   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      idx_d   = idx_q;
      wdog_d  = wdog_q;
      error_d = error_q;
      case (state_q)
         IDLE: begin
            if (start && !abort) begin
               len_d   = msg_len;
               idx_d   = '0;
               wdog_d  = '0;
               error_d = 1'b0;
               state_d = KSA;
            end
         end
         KSA: begin
            wdog_d = wdog_q + TMO_W'(1);
            if (abort) begin
               state_d = SCRUB;
            end else if (ksa_ready) begin
               state_d = SETTLE;
            end else if (wdog_q == TMO_LAST) begin
               error_d = 1'b1;
               state_d = SCRUB;
            end
         end
         SETTLE: begin
            if (abort) begin
               state_d = SCRUB;
            end else if (len_q == '0) begin
               state_d = DONE;
            end else begin
               state_d = STREAM;
            end
         end
         STREAM: begin
            if (abort) begin
               state_d = SCRUB;
            end else begin
               if (prga_step) begin
                  idx_d = idx_q + LEN_W'(1);
               end
               // All bytes stepped: finish once the slot is empty or draining
               if (last_byte && (!out_valid || out_ready)) begin
                  state_d = DONE;
               end
            end
         end
         DONE:    state_d = SCRUB;
         SCRUB:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State, command and counter registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         ns_q    <= NS_INIT;
         len_q   <= '0;
         idx_q   <= '0;
         wdog_q  <= '0;
         error_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ns_q    <= ns_of_state(state_d);
         len_q   <= len_d;
         idx_q   <= idx_d;
         wdog_q  <= wdog_d;
         error_q <= error_d;
      end
   end

   assign ns       = ns_q;
   assign byte_idx = idx_q;
   assign busy     = (state_q != IDLE);
   assign done     = (state_q == DONE);
   assign error    = error_q;

endmodule
